// File: rtl/sag_pkg.sv
// Shared definitions for the SAG family of sequencers (sag_seq, later grp/inverse-SAG).
package sag_pkg;

  localparam int SAG_W     = 8;
  localparam int SAG_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS0 = 2'd1,
    PASS1 = 2'd2,
    DONE  = 2'd3
  } sag_state_t;

endpackage

// File: rtl/sag_seq_pext.sv
// Combinational parallel-extract network: mask-selected bits of data packed at the LSB end.
module pext #(
  parameter int W = 8
) (
  input  logic [W-1:0] data,
  input  logic [W-1:0] mask,
  output logic [W-1:0] result
);

  // Scan from the MSB and shift left so the lowest selected bit ends up at bit 0.
  always_comb begin
    result = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (mask[i]) result = {result[W-2:0], data[i]};
    end
  end

endmodule

// File: rtl/sag_seq.sv
// Two-pass sheep-and-goats sequencer sharing one pext instance.
// Optional build macro SAG_SEQ_FASTPATH_EN: identity masks (00/FF) skip straight to DONE.
//
//  state | meaning
//  IDLE  | waiting for an operand
//  PASS0 | pext(d, m) -> lo_q, popcount(m) -> cnt_q
//  PASS1 | pext(d, ~m) shifted above lo_q -> res_q
//  DONE  | result presented until out_ready
module sag_seq
  import sag_pkg::*;
#(
  parameter bit ACCEPT_ON_DRAIN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SAG_W-1:0]     in_data,
  input  logic [SAG_W-1:0]     in_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SAG_W-1:0]     out_data,
  output logic [SAG_CNT_W-1:0] out_cnt,
  output logic                 busy
);

  sag_state_t           state;
  logic [SAG_W-1:0]     d_q, m_q, lo_q, res_q;
  logic [SAG_CNT_W-1:0] cnt_q, pop_m;
  logic [SAG_W-1:0]     pext_d, pext_m, pext_out;
  logic                 accept, fast;

  assign in_ready  = (state == IDLE) || (ACCEPT_ON_DRAIN && (state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = res_q;
  assign out_cnt   = cnt_q;

`ifdef SAG_SEQ_FASTPATH_EN
  assign fast = (in_mask == '0) || (in_mask == '1);
`else
  assign fast = 1'b0;
`endif

  always_comb begin
    pop_m = '0;
    for (int i = 0; i < SAG_W; i++) pop_m = pop_m + SAG_CNT_W'(m_q[i]);
  end

  // Operand mux: pext inputs sit at zero outside the two passes.
  always_comb begin
    pext_d = '0;
    pext_m = '0;
    case (state)
      PASS0:   begin pext_d = d_q; pext_m = m_q;  end
      PASS1:   begin pext_d = d_q; pext_m = ~m_q; end
      default: ;
    endcase
  end

  pext #(.W(SAG_W)) u_pext (
    .data   (pext_d),
    .mask   (pext_m),
    .result (pext_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      d_q   <= '0;
      m_q   <= '0;
      lo_q  <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            d_q <= in_data;
            m_q <= in_mask;
            if (fast) begin
              res_q <= in_data;
              cnt_q <= in_mask[0] ? SAG_CNT_W'(SAG_W) : '0;
              state <= DONE;
            end else begin
              state <= PASS0;
            end
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
        PASS0: begin
          lo_q  <= pext_out;
          cnt_q <= pop_m;
          state <= PASS1;
        end
        PASS1: begin
          res_q <= lo_q | (pext_out << cnt_q);
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sag_seq.sv
// Directed, table-driven bench for sag_seq with backpressure, streaming and reset corner cases.
module tb_sag_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [7:0] in_mask = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [3:0] out_cnt;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sag_seq #(.ACCEPT_ON_DRAIN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic [7:0] mask;
    logic [7:0] exp_data;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: walk the bits, placing mask-1 bits first then mask-0 bits above them.
  function automatic logic [7:0] sag_ref(input logic [7:0] d, input logic [7:0] m);
    logic [7:0] r;
    int pos;
    r = 8'h00;
    pos = 0;
    for (int i = 0; i < 8; i++) if (m[i]) begin r[pos] = d[i]; pos++; end
    for (int i = 0; i < 8; i++) if (!m[i]) begin r[pos] = d[i]; pos++; end
    return r;
  endfunction

  function automatic int exp_lat(input logic [7:0] m);
`ifdef SAG_SEQ_FASTPATH_EN
    return (m == 8'h00 || m == 8'hFF) ? 1 : 3;
`else
    return 3;
`endif
  endfunction

  // Presents one operand, returns edges from the accept edge (inclusive) to out_valid.
  task automatic issue(input logic [7:0] d, input logic [7:0] m, output int lat);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_mask  = m;
    guard = 0;
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    check("in_ready_before_accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  int lat;
  int ridx, idx, last_cyc;
  bit acc, spurious;
  logic [7:0] ops_d[4], ops_m[4], ops_e[4];

  initial begin
    vecs[0] = '{8'hB4, 8'hAA, 8'h6C, 4'd4};
    vecs[1] = '{8'h81, 8'h80, 8'h03, 4'd1};
    vecs[2] = '{8'h5A, 8'h00, 8'h5A, 4'd0};
    vecs[3] = '{8'h5A, 8'hFF, 8'h5A, 4'd8};
    vecs[4] = '{8'hF0, 8'h0F, 8'hF0, 4'd4};
    vecs[5] = '{8'h80, 8'h01, 8'h80, 4'd1};
    vecs[6] = '{8'h01, 8'h01, 8'h01, 4'd1};

    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_cnt", out_cnt, 4'h0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      issue(vecs[v].data, vecs[v].mask, lat);
      check($sformatf("vec%0d_latency", v), lat, exp_lat(vecs[v].mask));
      check($sformatf("vec%0d_out_data", v), out_data, vecs[v].exp_data);
      check($sformatf("vec%0d_out_cnt", v), out_cnt, vecs[v].exp_cnt);
      drain();
      check($sformatf("vec%0d_idle_after_drain", v), busy, 1'b0);
    end

    // Backpressure with a second operand waiting, accepted on the drain cycle.
    issue(8'hB4, 8'hAA, lat);
    check("bp_latency", lat, 3);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h81;
    in_mask  = 8'h80;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold_data_c%0d", c), out_data, 8'h6C);
      check($sformatf("bp_hold_cnt_c%0d", c), out_cnt, 4'd4);
      check($sformatf("bp_in_ready_low_c%0d", c), in_ready, 1'b0);
      check($sformatf("bp_out_valid_c%0d", c), out_valid, 1'b1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_on_drain", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_second_in_pass0_busy", busy, 1'b1);
    check("bp_second_in_pass0_valid", out_valid, 1'b0);
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("bp_second_latency", lat, 3);
    check("bp_second_data", out_data, 8'h03);
    check("bp_second_cnt", out_cnt, 4'd1);
    drain();

    // Back-to-back stream: masks avoid 00/FF so spacing is 3 in either build.
    for (int k = 0; k < 4; k++) begin
      ops_d[k] = 8'($urandom_range(0, 255));
      ops_m[k] = 8'($urandom_range(1, 254));
      ops_e[k] = sag_ref(ops_d[k], ops_m[k]);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = ops_d[0];
    in_mask   = ops_m[0];
    idx = 0;
    ridx = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 60 && ridx < 4; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (out_valid) begin
        check($sformatf("b2b_data%0d", ridx), out_data, ops_e[ridx]);
        if (ridx > 0) check($sformatf("b2b_spacing%0d", ridx), cyc - last_cyc, 3);
        last_cyc = cyc;
        ridx++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) begin
          in_data = ops_d[idx];
          in_mask = ops_m[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("b2b_result_count", ridx, 4);
    out_ready = 1'b0;
    in_valid  = 1'b0;

    // Reset during PASS1 discards the operation.
    issue(8'hB4, 8'hAA, lat);
    drain();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h81;
    in_mask  = 8'h80;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("mid_busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_data", out_data, 8'h00);
    check("mid_rst_out_cnt", out_cnt, 4'h0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid || busy) spurious = 1'b1;
    end
    check("mid_rst_no_spurious", spurious, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
